adc0809_responder: RTL and testbench

- Synthesizable FPGA emulation of the ADC0809 chip side of the ADC0809 bus. It answers an ADC0809 controller's ALE/START/OE/ad_clk with EOC and D[7:0].
- Used for bench and board loopback of ADC controller logic when no physical ADC0809 is fitted.
- Conversion values come from per-channel digital "analog" inputs, selected by a latched 3-bit address.

---
 rtl/adc0809_responder.sv | 162 ++++++++++++++++
 tb/tb_adc0809_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc0809_responder.sv
// ADC0809 chip-side emulator: answers ALE/START/OE/ad_clk with EOC and D.
// Optional sticky overrun flag when built with ADC0809_OVERRUN_EN.
module adc0809_responder #(
   parameter int NUM_CH      = 8,
   parameter int EOC_LAT     = 2,
   parameter int CONV_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ad_clk,
   input  logic                  start,
   input  logic                  ale,
   input  logic [2:0]            addr,
   input  logic                  OE,
   input  logic [8*NUM_CH-1:0]   ch_data,
   output logic                  EOC,
   output logic [7:0]            D,
   output logic                  D_oe
`ifdef ADC0809_OVERRUN_EN
   ,
   output logic                  overrun
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_CONV,
      S_DONE
   } state_t;

   // bit order: {OE, ale, start, ad_clk}
   logic [3:0] r_s1, r_s2, r_s3;
   logic [3:0] w_rise, w_fall;
   logic       w_st_rise, w_st_fall, w_ale_rise, w_ac_rise, w_oe_s;

   state_t     r_state, w_nxt;
   logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [7:0] r_sample, r_result, r_d, w_sel_data;
   logic [2:0] r_ch_sel;
   logic       r_eoc, r_d_oe;
   logic       w_ld_sample, w_ld_result;

   assign w_rise     = r_s2 & ~r_s3;
   assign w_fall     = ~r_s2 & r_s3;
   assign w_ac_rise  = w_rise[0];
   assign w_st_rise  = w_rise[1];
   assign w_st_fall  = w_fall[1];
   assign w_ale_rise = w_rise[2];
   assign w_oe_s     = r_s2[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= {OE, ale, start, ad_clk};
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_comb begin
      w_sel_data = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_ch_sel == 3'(i)) w_sel_data = ch_data[8*i +: 8];
      end
   end

   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   always_comb begin
      w_nxt       = r_state;
      w_cnt_nxt   = r_cnt;
      w_ld_sample = 1'b0;
      w_ld_result = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_st_rise) w_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (w_st_fall) begin
               w_nxt       = S_DELAY;
               w_ld_sample = 1'b1;
            end
         end
         S_DELAY: begin
            if (w_st_rise) begin
               w_nxt = S_ARMED;
            end else if (w_ac_rise) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == 8'(EOC_LAT)) w_nxt = S_CONV;
            end
         end
         S_CONV: begin
            if (w_st_rise) begin
               w_nxt = S_ARMED;
            end else if (w_ac_rise) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == 8'(CONV_CYCLES)) begin
                  w_nxt       = S_DONE;
                  w_ld_result = 1'b1;
               end
            end
         end
         default: w_nxt = S_IDLE;
      endcase
      // counter restarts from zero on every state entry
      if (w_nxt != r_state) w_cnt_nxt = 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 8'h00;
         r_eoc    <= 1'b1;
         r_sample <= 8'h00;
         r_result <= 8'h00;
         r_ch_sel <= 3'd0;
         r_d      <= 8'h00;
         r_d_oe   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         r_eoc   <= (w_nxt != S_CONV);
         if (w_ld_sample) r_sample <= w_sel_data;
         if (w_ld_result) r_result <= r_sample;
         if (w_ale_rise)  r_ch_sel <= addr;
         r_d_oe <= w_oe_s;
         r_d    <= w_oe_s ? r_result : 8'h00;
      end
   end

`ifdef ADC0809_OVERRUN_EN
   logic r_oe_seen, r_overrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oe_seen <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_ld_result)
            r_oe_seen <= 1'b0;
         else if (r_state == S_DONE && w_oe_s)
            r_oe_seen <= 1'b1;
         if (w_st_rise &&
             (r_state == S_DELAY || r_state == S_CONV ||
              (r_state == S_DONE && !r_oe_seen)))
            r_overrun <= 1'b1;
      end
   end

   assign overrun = r_overrun;
`endif

   assign EOC  = r_eoc;
   assign D    = r_d;
   assign D_oe = r_d_oe;

endmodule

// File: tb/tb_adc0809_responder.sv
// Randomised bench for adc0809_responder against an event-level model.
// Build with ADC0809_OVERRUN_EN to also check the overrun flag.
module tb_adc0809_responder;

   localparam int NCH = 8;
   localparam int LAT = 2;
   localparam int CC  = 64;

   localparam int P_IDLE  = 0;
   localparam int P_ARMED = 1;
   localparam int P_DELAY = 2;
   localparam int P_CONV  = 3;
   localparam int P_DONE  = 4;

   logic        clk = 0, rst_n = 0, ad_clk = 0;
   logic        start = 0, ale = 0, OE = 0;
   logic [2:0]  addr = 0;
   logic [63:0] chd = 0;
   logic [31:0] chd4 = 0;
   logic        eoc, eoc4, doe, doe4;
   logic [7:0]  d, d4;
`ifdef ADC0809_OVERRUN_EN
   logic        ovr, ovr4;
`endif

   int total = 0;
   int bad   = 0;

   adc0809_responder #(.NUM_CH(NCH), .EOC_LAT(LAT), .CONV_CYCLES(CC)) u_dut (
      .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .start(start),
      .ale(ale), .addr(addr), .OE(OE), .ch_data(chd),
      .EOC(eoc), .D(d), .D_oe(doe)
`ifdef ADC0809_OVERRUN_EN
      , .overrun(ovr)
`endif
   );

   adc0809_responder #(.NUM_CH(4), .EOC_LAT(LAT), .CONV_CYCLES(CC)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .start(start),
      .ale(ale), .addr(addr), .OE(OE), .ch_data(chd4),
      .EOC(eoc4), .D(d4), .D_oe(doe4)
`ifdef ADC0809_OVERRUN_EN
      , .overrun(ovr4)
`endif
   );

   always #5 clk = ~clk;

   initial forever begin
      repeat (4) @(negedge clk);
      ad_clk = ~ad_clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [2:0] m_sel;
   logic [7:0] m_sample, m_result, m_d;
   logic       m_eoc, m_doe, m_seen, m_ovr;
   int         m_ph, m_rem;
   logic [2:0] h_st, h_al, h_ac, h_oe;
   logic       sr, sf, ar, cr, oes;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_sel = 0; m_sample = 0; m_result = 0; m_d = 0;
         m_eoc = 1; m_doe = 0; m_seen = 0; m_ovr = 0;
         m_ph = P_IDLE; m_rem = 0;
         h_st = 0; h_al = 0; h_ac = 0; h_oe = 0;
      end else begin
         // inputs act three clocks after they change
         sr  = h_st[1] & ~h_st[2];
         sf  = ~h_st[1] & h_st[2];
         ar  = h_al[1] & ~h_al[2];
         cr  = h_ac[1] & ~h_ac[2];
         oes = h_oe[1];
         m_doe = oes;
         m_d   = oes ? m_result : 8'h00;
         if (sr && (m_ph == P_DELAY || m_ph == P_CONV ||
                    (m_ph == P_DONE && !m_seen)))
            m_ovr = 1;
         if (m_ph == P_DONE && oes) m_seen = 1;
         if ((m_ph == P_IDLE || m_ph == P_DONE) && sr) begin
            m_ph = P_ARMED;
         end else if (m_ph == P_ARMED) begin
            if (sf) begin
               m_ph     = P_DELAY;
               m_rem    = LAT;
               m_sample = (int'(m_sel) < NCH) ? chd[m_sel*8 +: 8] : 8'h00;
            end
         end else if (m_ph == P_DELAY || m_ph == P_CONV) begin
            if (sr) begin
               m_ph = P_ARMED;
            end else if (cr) begin
               m_rem--;
               if (m_rem == 0 && m_ph == P_DELAY) begin
                  m_ph  = P_CONV;
                  m_rem = CC;
               end else if (m_rem == 0) begin
                  m_ph     = P_DONE;
                  m_result = m_sample;
                  m_seen   = 0;
               end
            end
         end
         if (ar) m_sel = addr;
         m_eoc = (m_ph != P_CONV);
         h_st = {h_st[1:0], start};
         h_al = {h_al[1:0], ale};
         h_ac = {h_ac[1:0], ad_clk};
         h_oe = {h_oe[1:0], OE};
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("eoc", 32'(eoc), 32'(m_eoc));
         chk("eoc4", 32'(eoc4), 32'(m_eoc));
         chk("d", 32'(d), 32'(m_d));
         chk("d_oe", 32'(doe), 32'(m_doe));
`ifdef ADC0809_OVERRUN_EN
         chk("overrun", 32'(ovr), 32'(m_ovr));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [2:0] a);
      @(negedge clk);
      addr = a; ale = 1; start = 1;
      tick(4);
      start = 0; ale = 0;
   endtask

   task automatic wait_eoc(input logic lvl, input int budget,
                           input string nm, output int n);
      n = 0;
      while (eoc !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(eoc), 32'(lvl));
   endtask

   task automatic conv(input logic [2:0] a, output int lat, output int len);
      pulse(a);
      wait_eoc(1'b0, 200, "eoc_fall", lat);
      wait_eoc(1'b1, 1000, "eoc_rise", len);
   endtask

   task automatic read_d(input logic [7:0] exp, input string nm);
      @(negedge clk);
      OE = 1;
      tick(4);
      chk(nm, 32'(d), 32'(exp));
      chk("d_oe_on", 32'(doe), 32'd1);
      OE = 0;
      tick(4);
      chk("d_off", 32'(d), 32'h00);
   endtask

   int lat, len, n;
   logic [2:0] a;

   initial begin
      tick(3);
      rst_n = 1;
      repeat (100) begin
         @(negedge clk);
         chk("idle_eoc", 32'(eoc), 32'd1);
         chk("idle_d", 32'(d), 32'h00);
         chk("idle_doe", 32'(doe), 32'd0);
      end

      // ch3 = A5, timing of EOC
      chd[3*8 +: 8] = 8'hA5;
      chd4 = $urandom;
      conv(3'd3, lat, len);
      total++;
      if (lat < 11 || lat > 27) begin
         bad++;
         $display("FAIL eoc_latency: got %0d want 11..27", lat);
      end
      chk("conv_len", 32'(len), 32'd512);
      @(negedge clk);
      OE = 1;
      @(posedge clk); @(posedge clk); #1;
      chk("oe_2clk", 32'(d), 32'h00);
      @(posedge clk); #1;
      chk("oe_3clk_d", 32'(d), 32'hA5);
      chk("oe_3clk_doe", 32'(doe), 32'd1);
      @(negedge clk);
      OE = 0;
      tick(4);
      chk("oe_off_d", 32'(d), 32'h00);

      // back to back ch0 / ch7
      chd[0 +: 8]    = 8'h00;
      chd[7*8 +: 8]  = 8'hFF;
      conv(3'd0, lat, len);
      chk("ch0_len", 32'(len), 32'd512);
      read_d(8'h00, "ch0_d");
      conv(3'd7, lat, len);
      chk("ch7_len", 32'(len), 32'd512);
      read_d(8'hFF, "ch7_d");

      // abort at ad_clk edge 30 of the conversion
      chd[5*8 +: 8] = 8'h5A;
      pulse(3'd5);
      wait_eoc(1'b0, 200, "ab_fall", lat);
      repeat (30) @(posedge ad_clk);
      @(negedge clk);
      OE = 1;
      tick(4);
      chk("ab_prev_d", 32'(d), 32'hFF);
      chk("ab_still_low", 32'(eoc), 32'd0);
      @(negedge clk);
      addr = 3'd5; ale = 1; start = 1;
      wait_eoc(1'b1, 10, "ab_rise", n);
      total++;
      if (n > 4) begin
         bad++;
         $display("FAIL abort_eoc_high: got %0d clk want <=4", n);
      end
      chk("ab_keep_d", 32'(d), 32'hFF);
`ifdef ADC0809_OVERRUN_EN
      chk("ab_overrun", 32'(ovr), 32'd1);
`endif
      tick(4);
      start = 0; ale = 0;
      OE = 0;
      wait_eoc(1'b0, 200, "ab2_fall", lat);
      wait_eoc(1'b1, 1000, "ab2_rise", len);
      chk("ab2_len", 32'(len), 32'd512);
      read_d(8'h5A, "ab2_d");

      // reset in the middle of a conversion
      @(negedge clk);
      OE = 1;
      pulse(3'd3);
      wait_eoc(1'b0, 200, "rs_fall", lat);
      tick(100);
      rst_n = 0;
      #1;
      chk("rst_eoc", 32'(eoc), 32'd1);
      chk("rst_d", 32'(d), 32'h00);
      chk("rst_doe", 32'(doe), 32'd0);
      tick(3);
      OE = 0;
      rst_n = 1;
      n = 0;
      repeat (700) begin
         @(negedge clk);
         if (eoc !== 1'b1) n++;
      end
      chk("rst_no_conv", 32'(n), 32'd0);

      // four-channel instance: out-of-range address reads zero
      chd4 = 32'hC3B2_A190;
      conv(3'd6, lat, len);
      @(negedge clk);
      OE = 1;
      tick(4);
      chk("nch4_addr6", 32'(d4), 32'h00);
      OE = 0;
      conv(3'd2, lat, len);
      @(negedge clk);
      OE = 1;
      tick(4);
      chk("nch4_addr2", 32'(d4), 32'hB2);
      OE = 0;
      tick(4);

      // randomised conversions, some aborted, random OE
      repeat (10) begin
         a   = 3'($urandom_range(0, 7));
         chd = {$urandom, $urandom};
         @(negedge clk);
         OE = 1'($urandom_range(0, 1));
         pulse(a);
         wait_eoc(1'b0, 200, "rnd_fall", lat);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 60)) @(posedge ad_clk);
            @(negedge clk);
            OE = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            pulse(a);
            wait_eoc(1'b0, 200, "rnd_fall2", lat);
         end
         wait_eoc(1'b1, 1000, "rnd_rise", len);
         chk("rnd_len", 32'(len), 32'd512);
         read_d(chd[a*8 +: 8], "rnd_d");
      end

      tick(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
